clock_set_cu: RTL and testbench
===============================

Name: clock_set_cu

Overview:
- Control unit that sequences time-setting for the clock datapath.
- Button pulses enter edit mode, select a field (hour/min/sec), adjust it with wrap, then commit via a one-cycle load strobe into the clock counters.
- Drives the display-side hour/min/sec plus a blink flag, so the FND controller shows edit values and blanks the selected field.
- Sits between the button debouncers and the clock datapath / fnd_controller.

Parameters:
- BLINK_DIV, 50_000_000, clk cycles per blink half-period (0.5 s at 100 MHz).
- TIMEOUT_CYC, 1_000_000_000, idle cycles before auto-abort (used only with CLOCK_SET_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- btn_set  in  1  one-cycle debounced pulse: enter edit / commit
- btn_next  in  1  one-cycle pulse: advance edit field
- btn_up  in  1  one-cycle pulse: increment field
- btn_down  in  1  one-cycle pulse: decrement field
- cur_hour  in  5  live hour from clock datapath, 0..23
- cur_min  in  6  live minute, 0..59
- cur_sec  in  6  live second, 0..59
- load  out  1  one-cycle strobe: datapath loads load_* values
- load_hour  out  5  committed hour
- load_min  out  6  committed minute
- load_sec  out  6  committed second
- edit_active  out  1  high in any EDIT_* state
- edit_field  out  2  0=hour, 1=min, 2=sec; 3 never driven
- blink  out  1  1=selected field visible, 0=blank; held 1 when not editing
- disp_hour  out  5  edit_hour when edit_active, else cur_hour (combinational mux)
- disp_min  out  6  same rule as disp_hour
- disp_sec  out  6  same rule as disp_hour

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset state: IDLE; load=0; load_*=0; edit regs=0; edit_field=0; blink=1; blink counter=0.
- State IDLE, on btn_set:
  - capture cur_* into edit_hour/min/sec;
  - go to EDIT_HOUR; blink=1; counter cleared.
- States EDIT_HOUR/EDIT_MIN/EDIT_SEC:
  - btn_next: HOUR->MIN->SEC->HOUR.
  - btn_up: field+1, wrapping 23->0 (hour) and 59->0 (min/sec).
  - btn_down: field-1, wrapping 0->23 and 0->59.
  - btn_set: go to COMMIT.
- State COMMIT (exactly one cycle):
  - load=1, load_* = edit regs;
  - next state IDLE; load returns to 0.
- Latency:
  - Pulse sampled at edge n; new state/edit value visible after edge n.
  - load is high during cycle n+1 after the commit btn_set.
- Simultaneous pulses: priority set > next > up/down.
  - up and down together: no change.
  - Only the highest-priority action is taken.
- Buttons in IDLE other than btn_set are ignored. All buttons are ignored in COMMIT.
- Blink:
  - Counter counts 0..BLINK_DIV-1 in EDIT_*; at the terminal count blink toggles and the counter returns to 0.
  - Any up/down/next press forces blink=1 and clears the counter.
  - In IDLE/COMMIT: blink=1, counter held at 0.
- Edit registers are frozen during edit; live cur_* changes are not tracked.
- Out-of-range captured values (hour>23, min/sec>59) are clamped to 0 at capture.
- Reset mid-edit: returns to IDLE with no load pulse.

Optional Feature:
- Macro CLOCK_SET_TIMEOUT_EN.
- Defined: an inactivity counter runs in EDIT_*, cleared by any button pulse. On reaching TIMEOUT_CYC-1 the FSM returns to IDLE without a load (edit discarded); edit_active drops the next cycle.
- Undefined: no counter; edit mode persists until btn_set or reset.

Decomposition:
- Package clock_set_pkg:
  - state encoding IDLE/EDIT_HOUR/EDIT_MIN/EDIT_SEC/COMMIT;
  - field codes FLD_HOUR=0, FLD_MIN=1, FLD_SEC=2;
  - constants HOUR_MAX=23, MIN_MAX=59; widths HOUR_W=5, MS_W=6.
- One sub-module, wrap_updown: parameterised width/max; inputs val, up, down; output next value with wrap. Instantiated once per field.

Test Plan:
- Enter/exit unchanged: cur=09:56:34; set, set -> load=1 for exactly 1 cycle with 9/56/34; edit_active high between the presses.
- Wrap: enter at 23:59:59; up on hour -> 0; next, up -> min 0; next, down -> sec 58; set -> load 0/0/58.
- Field cycling and priority: 3x next -> edit_field 0,1,2,0; set+up in the same cycle -> COMMIT with value unchanged; up+down in the same cycle -> no change.
- Blink (BLINK_DIV=4): in edit, blink toggles every 4 cycles; up press -> blink=1 and counter restarts; IDLE -> blink=1.
- Reset mid-edit: hour edited to 12, rst 1 cycle -> IDLE, load never asserted, outputs at reset values.
- Timeout (macro on, TIMEOUT_CYC=20): enter edit, no buttons -> IDLE after 20 cycles, no load; with a press at cycle 15 -> timeout at cycle 35.

Source files
------------

// File: rtl/clock_set_pkg.sv
// Shared definitions for the clock time-setting control unit.
//   - state_t     : control FSM states
//   - FLD_*       : edit_field codes driven to the display side
//   - HOUR_*/MS_* : field widths and maximum legal values
//   - clamp_*     : force out-of-range live values to 0 when captured
package clock_set_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EDIT_HOUR = 3'd1,
    EDIT_MIN  = 3'd2,
    EDIT_SEC  = 3'd3,
    COMMIT    = 3'd4
  } state_t;

  localparam logic [1:0] FLD_HOUR = 2'd0;
  localparam logic [1:0] FLD_MIN  = 2'd1;
  localparam logic [1:0] FLD_SEC  = 2'd2;

  localparam int HOUR_W   = 5;
  localparam int MS_W     = 6;
  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  function automatic logic [HOUR_W-1:0] clamp_hour(input logic [HOUR_W-1:0] v);
    return (v > HOUR_W'(HOUR_MAX)) ? '0 : v;
  endfunction

  function automatic logic [MS_W-1:0] clamp_ms(input logic [MS_W-1:0] v);
    return (v > MS_W'(MIN_MAX)) ? '0 : v;
  endfunction

  function automatic logic is_edit(input state_t s);
    return (s == EDIT_HOUR) || (s == EDIT_MIN) || (s == EDIT_SEC);
  endfunction

endpackage

// File: rtl/wrap_updown.sv
// Modulo up/down step for one time field.
//   val  : current field value (0..MAX)
//   up   : request +1, MAX wraps to 0
//   down : request -1, 0 wraps to MAX
//   nxt  : resulting value; up and down together leave the value unchanged
module wrap_updown #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic [W-1:0] val,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = val;
    if (up && !down) begin
      nxt = (val == W'(MAX)) ? '0 : val + W'(1);
    end else if (down && !up) begin
      nxt = (val == '0) ? W'(MAX) : val - W'(1);
    end
  end

endmodule

// File: rtl/clock_set_cu.sv
// Time-setting control unit for the clock datapath.
// btn_set enters edit mode (capturing the live time), btn_next cycles the
// selected field hour->min->sec, btn_up/btn_down adjust it with wrap, and a
// second btn_set commits through a one-cycle load strobe.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   btn_set/next/up/down         : one-cycle debounced button pulses
//   cur_hour/min/sec             : live time from the clock datapath
//   load, load_hour/min/sec      : commit strobe and committed values
//   edit_active, edit_field      : edit-mode flag and selected field code
//   blink                        : 1 = selected field visible, 0 = blank
//   disp_hour/min/sec            : edit values while editing, else live time
// Optional build macro: CLOCK_SET_TIMEOUT_EN adds an inactivity timeout that
// abandons the edit (no load) after TIMEOUT_CYC idle cycles.
module clock_set_cu
  import clock_set_pkg::*;
#(
  parameter int BLINK_DIV = 50_000_000
`ifdef CLOCK_SET_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1_000_000_000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_set,
  input  logic              btn_next,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MS_W-1:0]   cur_min,
  input  logic [MS_W-1:0]   cur_sec,
  output logic              load,
  output logic [HOUR_W-1:0] load_hour,
  output logic [MS_W-1:0]   load_min,
  output logic [MS_W-1:0]   load_sec,
  output logic              edit_active,
  output logic [1:0]        edit_field,
  output logic              blink,
  output logic [HOUR_W-1:0] disp_hour,
  output logic [MS_W-1:0]   disp_min,
  output logic [MS_W-1:0]   disp_sec
);

  localparam int BLINK_CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t                 state_q, state_d;
  logic [HOUR_W-1:0]      edit_hour_q, edit_hour_d;
  logic [MS_W-1:0]        edit_min_q, edit_min_d;
  logic [MS_W-1:0]        edit_sec_q, edit_sec_d;
  logic                   load_q, load_d;
  logic [HOUR_W-1:0]      load_hour_q, load_hour_d;
  logic [MS_W-1:0]        load_min_q, load_min_d;
  logic [MS_W-1:0]        load_sec_q, load_sec_d;
  logic                   blink_q, blink_d;
  logic [BLINK_CNT_W-1:0] blink_cnt_q, blink_cnt_d;

  logic                   editing;
  logic                   adj_en;
  logic [HOUR_W-1:0]      hour_nxt;
  logic [MS_W-1:0]        min_nxt, sec_nxt;

  assign editing = is_edit(state_q);
  // up/down only act when no higher-priority button arrived in the same cycle
  assign adj_en  = editing && !btn_set && !btn_next;

  wrap_updown #(.W(HOUR_W), .MAX(HOUR_MAX)) u_wrap_hour (
    .val  (edit_hour_q),
    .up   (adj_en && btn_up   && (state_q == EDIT_HOUR)),
    .down (adj_en && btn_down && (state_q == EDIT_HOUR)),
    .nxt  (hour_nxt)
  );

  wrap_updown #(.W(MS_W), .MAX(MIN_MAX)) u_wrap_min (
    .val  (edit_min_q),
    .up   (adj_en && btn_up   && (state_q == EDIT_MIN)),
    .down (adj_en && btn_down && (state_q == EDIT_MIN)),
    .nxt  (min_nxt)
  );

  wrap_updown #(.W(MS_W), .MAX(MIN_MAX)) u_wrap_sec (
    .val  (edit_sec_q),
    .up   (adj_en && btn_up   && (state_q == EDIT_SEC)),
    .down (adj_en && btn_down && (state_q == EDIT_SEC)),
    .nxt  (sec_nxt)
  );

`ifdef CLOCK_SET_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    edit_hour_d = edit_hour_q;
    edit_min_d  = edit_min_q;
    edit_sec_d  = edit_sec_q;
    load_d      = 1'b0;
    load_hour_d = load_hour_q;
    load_min_d  = load_min_q;
    load_sec_d  = load_sec_q;
    blink_d     = 1'b1;
    blink_cnt_d = '0;
`ifdef CLOCK_SET_TIMEOUT_EN
    to_cnt_d    = '0;
`endif

    case (state_q)
      IDLE: begin
        if (btn_set) begin
          edit_hour_d = clamp_hour(cur_hour);
          edit_min_d  = clamp_ms(cur_min);
          edit_sec_d  = clamp_ms(cur_sec);
          state_d     = EDIT_HOUR;
        end
      end

      EDIT_HOUR, EDIT_MIN, EDIT_SEC: begin
        edit_hour_d = hour_nxt;
        edit_min_d  = min_nxt;
        edit_sec_d  = sec_nxt;
        if (btn_set) begin
          state_d     = COMMIT;
          load_d      = 1'b1;
          load_hour_d = edit_hour_q;
          load_min_d  = edit_min_q;
          load_sec_d  = edit_sec_q;
        end else if (btn_next) begin
          case (state_q)
            EDIT_HOUR: state_d = EDIT_MIN;
            EDIT_MIN:  state_d = EDIT_SEC;
            default:   state_d = EDIT_HOUR;
          endcase
        end else if (btn_up || btn_down) begin
          // press keeps the field visible: defaults already give blink=1, cnt=0
        end else if (blink_cnt_q == BLINK_CNT_W'(BLINK_DIV - 1)) begin
          blink_d = !blink_q;
        end else begin
          blink_d     = blink_q;
          blink_cnt_d = blink_cnt_q + BLINK_CNT_W'(1);
        end
`ifdef CLOCK_SET_TIMEOUT_EN
        if (btn_set || btn_next || btn_up || btn_down) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          // abandon the edit silently; edit registers are recaptured on next entry
          state_d     = IDLE;
          blink_d     = 1'b1;
          blink_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end

      COMMIT: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      edit_hour_q <= '0;
      edit_min_q  <= '0;
      edit_sec_q  <= '0;
      load_q      <= 1'b0;
      load_hour_q <= '0;
      load_min_q  <= '0;
      load_sec_q  <= '0;
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      edit_hour_q <= edit_hour_d;
      edit_min_q  <= edit_min_d;
      edit_sec_q  <= edit_sec_d;
      load_q      <= load_d;
      load_hour_q <= load_hour_d;
      load_min_q  <= load_min_d;
      load_sec_q  <= load_sec_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

`ifdef CLOCK_SET_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  always_comb begin
    case (state_q)
      EDIT_MIN: edit_field = FLD_MIN;
      EDIT_SEC: edit_field = FLD_SEC;
      default:  edit_field = FLD_HOUR;
    endcase
  end

  assign load        = load_q;
  assign load_hour   = load_hour_q;
  assign load_min    = load_min_q;
  assign load_sec    = load_sec_q;
  assign edit_active = editing;
  assign blink       = blink_q;
  assign disp_hour   = editing ? edit_hour_q : cur_hour;
  assign disp_min    = editing ? edit_min_q  : cur_min;
  assign disp_sec    = editing ? edit_sec_q  : cur_sec;

endmodule

// File: tb/tb_clock_set_cu.sv
// Bench for clock_set_cu: table-driven vectors, hand-written blink / reset /
// timeout sequences, and randomized buttons against a behavioural model.
module tb_clock_set_cu;

  localparam int BDIV = 4;
`ifdef CLOCK_SET_TIMEOUT_EN
  localparam int TOC = 20;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_set = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0, cur_sec = '0;
  logic       load;
  logic [4:0] load_hour;
  logic [5:0] load_min, load_sec;
  logic       edit_active;
  logic [1:0] edit_field;
  logic       blink;
  logic [4:0] disp_hour;
  logic [5:0] disp_min, disp_sec;

  always #5 clk = ~clk;

  clock_set_cu #(
    .BLINK_DIV(BDIV)
`ifdef CLOCK_SET_TIMEOUT_EN
    , .TIMEOUT_CYC(TOC)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .btn_set(btn_set), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .load(load), .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
    .edit_active(edit_active), .edit_field(edit_field), .blink(blink),
    .disp_hour(disp_hour), .disp_min(disp_min), .disp_sec(disp_sec)
  );

  int errors = 0;
  int checks = 0;
  int loads_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: mode 0=idle, 1=editing, 2=commit cycle
  int MOD[3] = '{24, 60, 60};
  int m_mode, m_fld, m_blink, m_bcnt, m_load, m_idle;
  int m_v[3];
  int m_lv[3];

  function automatic int clampv(input int v, input int m);
    return (v < m) ? v : 0;
  endfunction

  task automatic model_step(input bit r, s, n, u, d, input int ch, cm, cs);
    if (r) begin
      m_mode = 0; m_fld = 0; m_blink = 1; m_bcnt = 0; m_load = 0; m_idle = 0;
      m_v = '{0, 0, 0};
      m_lv = '{0, 0, 0};
    end else begin
      m_load = 0;
      case (m_mode)
        0: begin
          m_blink = 1; m_bcnt = 0; m_idle = 0;
          if (s) begin
            m_v[0] = clampv(ch, 24); m_v[1] = clampv(cm, 60); m_v[2] = clampv(cs, 60);
            m_fld = 0; m_mode = 1;
          end
        end
        1: begin
          if (s) begin
            m_lv = m_v; m_load = 1; m_mode = 2; m_blink = 1; m_bcnt = 0;
          end else if (n) begin
            m_fld = (m_fld + 1) % 3; m_blink = 1; m_bcnt = 0;
          end else if (u || d) begin
            if (u && !d) m_v[m_fld] = (m_v[m_fld] + 1) % MOD[m_fld];
            else if (d && !u) m_v[m_fld] = (m_v[m_fld] + MOD[m_fld] - 1) % MOD[m_fld];
            m_blink = 1; m_bcnt = 0;
          end else if (m_bcnt == BDIV - 1) begin
            m_blink = 1 - m_blink; m_bcnt = 0;
          end else begin
            m_bcnt++;
          end
`ifdef CLOCK_SET_TIMEOUT_EN
          if (s || n || u || d) m_idle = 0;
          else if (m_idle == TOC - 1) begin
            m_mode = 0; m_idle = 0; m_blink = 1; m_bcnt = 0;
          end else m_idle++;
`endif
        end
        default: begin
          m_mode = 0; m_blink = 1; m_bcnt = 0;
        end
      endcase
    end
  endtask

  task automatic check_model();
    chk("m_load", load, m_load);
    chk("m_load_hour", load_hour, m_lv[0]);
    chk("m_load_min", load_min, m_lv[1]);
    chk("m_load_sec", load_sec, m_lv[2]);
    chk("m_edit_active", edit_active, (m_mode == 1) ? 1 : 0);
    chk("m_edit_field", edit_field, (m_mode == 1) ? m_fld : 0);
    chk("m_blink", blink, m_blink);
    chk("m_disp_hour", disp_hour, (m_mode == 1) ? m_v[0] : int'(cur_hour));
    chk("m_disp_min", disp_min, (m_mode == 1) ? m_v[1] : int'(cur_min));
    chk("m_disp_sec", disp_sec, (m_mode == 1) ? m_v[2] : int'(cur_sec));
  endtask

  // One clock: drive inputs, advance model at the edge, check 1 time unit later
  task automatic cyc(input bit r, s, n, u, d);
    rst = r; btn_set = s; btn_next = n; btn_up = u; btn_down = d;
    @(posedge clk);
    model_step(r, s, n, u, d, int'(cur_hour), int'(cur_min), int'(cur_sec));
    #1;
    check_model();
    if (load === 1'b1) loads_seen++;
    rst = 0; btn_set = 0; btn_next = 0; btn_up = 0; btn_down = 0;
  endtask

  task automatic set_cur(input int h, m, s);
    cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
  endtask

  typedef struct {
    bit s, n, u, d;
    int ch, cm, cs;
    bit e_load;
    int e_lh, e_lm, e_ls;
    bit e_act;
    int e_fld;
    int e_dh, e_dm, e_ds;
  } vec_t;

  function automatic vec_t mk(input bit s, n, u, d, input int ch, cm, cs,
                              input bit el, input int lh, lm, ls,
                              input bit ea, input int ef, input int dh, dm, ds);
    vec_t v;
    v.s = s; v.n = n; v.u = u; v.d = d; v.ch = ch; v.cm = cm; v.cs = cs;
    v.e_load = el; v.e_lh = lh; v.e_lm = lm; v.e_ls = ls;
    v.e_act = ea; v.e_fld = ef; v.e_dh = dh; v.e_dm = dm; v.e_ds = ds;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    // enter/exit unchanged at 09:56:34
    vt.push_back(mk(1,0,0,0,  9,56,34, 0, 0, 0, 0, 1,0,  9,56,34));
    vt.push_back(mk(1,0,0,0,  9,56,34, 1, 9,56,34, 0,0,  9,56,34));
    vt.push_back(mk(0,0,0,0,  9,56,34, 0, 9,56,34, 0,0,  9,56,34));
    // wrap at 23:59:59
    vt.push_back(mk(1,0,0,0, 23,59,59, 0, 9,56,34, 1,0, 23,59,59));
    vt.push_back(mk(0,0,1,0, 23,59,59, 0, 9,56,34, 1,0,  0,59,59));
    vt.push_back(mk(0,1,0,0, 23,59,59, 0, 9,56,34, 1,1,  0,59,59));
    vt.push_back(mk(0,0,1,0, 23,59,59, 0, 9,56,34, 1,1,  0, 0,59));
    vt.push_back(mk(0,1,0,0, 23,59,59, 0, 9,56,34, 1,2,  0, 0,59));
    vt.push_back(mk(0,0,0,1, 23,59,59, 0, 9,56,34, 1,2,  0, 0,58));
    vt.push_back(mk(1,0,0,0, 23,59,59, 1, 0, 0,58, 0,0, 23,59,59));
    vt.push_back(mk(0,0,0,0, 23,59,59, 0, 0, 0,58, 0,0, 23,59,59));
    // field cycling and priority at 10:20:30
    vt.push_back(mk(1,0,0,0, 10,20,30, 0, 0, 0,58, 1,0, 10,20,30));
    vt.push_back(mk(0,1,0,0, 10,20,30, 0, 0, 0,58, 1,1, 10,20,30));
    vt.push_back(mk(0,1,0,0, 10,20,30, 0, 0, 0,58, 1,2, 10,20,30));
    vt.push_back(mk(0,1,0,0, 10,20,30, 0, 0, 0,58, 1,0, 10,20,30));
    vt.push_back(mk(0,0,1,1, 10,20,30, 0, 0, 0,58, 1,0, 10,20,30));
    vt.push_back(mk(1,0,1,0, 10,20,30, 1,10,20,30, 0,0, 10,20,30));
    vt.push_back(mk(0,0,0,0, 10,20,30, 0,10,20,30, 0,0, 10,20,30));
    // out-of-range capture clamps to 0
    vt.push_back(mk(1,0,0,0, 31,63,60, 0,10,20,30, 1,0,  0, 0, 0));
    vt.push_back(mk(1,0,0,0, 31,63,60, 1, 0, 0, 0, 0,0, 31,63,60));
    vt.push_back(mk(0,0,0,0, 31,63,60, 0, 0, 0, 0, 0,0, 31,63,60));

    // reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_load", load, 0);
    chk("rst_load_hour", load_hour, 0);
    chk("rst_edit_active", edit_active, 0);
    chk("rst_edit_field", edit_field, 0);
    chk("rst_blink", blink, 1);

    // table vectors
    foreach (vt[i]) begin
      set_cur(vt[i].ch, vt[i].cm, vt[i].cs);
      cyc(0, vt[i].s, vt[i].n, vt[i].u, vt[i].d);
      chk($sformatf("vec%0d_load", i), load, vt[i].e_load);
      chk($sformatf("vec%0d_load_hms", i), {load_hour, load_min, load_sec},
          {5'(vt[i].e_lh), 6'(vt[i].e_lm), 6'(vt[i].e_ls)});
      chk($sformatf("vec%0d_active", i), edit_active, vt[i].e_act);
      chk($sformatf("vec%0d_field", i), edit_field, vt[i].e_fld);
      chk($sformatf("vec%0d_disp", i), {disp_hour, disp_min, disp_sec},
          {5'(vt[i].e_dh), 6'(vt[i].e_dm), 6'(vt[i].e_ds)});
    end

    // blink: toggles every BDIV idle cycles, a press forces it visible
    set_cur(1, 2, 3);
    cyc(0, 1, 0, 0, 0);
    chk("blink_entry", blink, 1);
    for (int k = 1; k <= 9; k++) begin
      cyc(0, 0, 0, 0, 0);
      chk($sformatf("blink_k%0d", k), blink, ((k / BDIV) % 2 == 0) ? 1 : 0);
    end
    cyc(0, 0, 0, 1, 0);
    chk("blink_after_up", blink, 1);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 0, 0, 0);
      chk($sformatf("blink_restart_k%0d", k), blink, (k < BDIV) ? 1 : 0);
    end
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("blink_idle", blink, 1);
    chk("blink_commit_val", {load_hour, load_min, load_sec}, {5'd2, 6'd2, 6'd3});

    // reset mid-edit: no load, everything back to reset values
    set_cur(0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 12; k++) cyc(0, 0, 0, 1, 0);
    chk("midedit_hour", disp_hour, 12);
    loads_seen = 0;
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0);
    chk("midedit_loads", loads_seen, 0);
    chk("midedit_load_hms", {load_hour, load_min, load_sec}, 17'd0);
    chk("midedit_active", edit_active, 0);
    chk("midedit_blink", blink, 1);
    chk("midedit_field", edit_field, 0);

`ifdef CLOCK_SET_TIMEOUT_EN
    // idle timeout: abandon after TOC idle cycles
    set_cur(4, 5, 6);
    loads_seen = 0;
    cyc(0, 1, 0, 0, 0);
    for (int k = 1; k <= TOC; k++) begin
      cyc(0, 0, 0, 0, 0);
      if (k == TOC - 1) chk("to_before", edit_active, 1);
      if (k == TOC) chk("to_after", edit_active, 0);
    end
    chk("to_no_load", loads_seen, 0);
    // a press at cycle 15 restarts the count, timing out at cycle 35
    cyc(0, 1, 0, 0, 0);
    for (int k = 1; k <= 35; k++) begin
      cyc(0, 0, 0, (k == 15) ? 1'b1 : 1'b0, 0);
      if (k == 34) chk("to2_before", edit_active, 1);
      if (k == 35) chk("to2_after", edit_active, 0);
    end
    chk("to2_no_load", loads_seen, 0);
`else
    // no timeout: edit mode persists indefinitely
    set_cur(4, 5, 6);
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 40; k++) cyc(0, 0, 0, 0, 0);
    chk("persist_active", edit_active, 1);
    cyc(0, 1, 0, 0, 0);
    chk("persist_commit", {load, load_hour, load_min, load_sec}, {1'b1, 5'd4, 6'd5, 6'd6});
`endif

    // randomized buttons and live time against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0)
        set_cur($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      else
        set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      cyc(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
